// File: rtl/program_loader.sv
// Boot-time loader: takes a framed byte stream, writes big-endian 16-bit words to RAM
// from address 0 and releases the CPU from reset once the frame checksum verifies.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_adr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic cpu_reset;
        logic done;
        logic error;
    } flags_t;

    // Status outputs are a pure function of the state being entered, so they are
    // loaded alongside the state register and never glitch.
    function automatic flags_t flags_for(input state_t s);
        flags_t f;
        f.rx_ready  = (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_CHK);
        f.busy      = (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_WR) || (s == S_CHK);
        f.cpu_reset = (s != S_DONE);
        f.done      = (s == S_DONE);
        f.error     = (s == S_ERROR);
        return f;
    endfunction

    state_t            state;
    flags_t            flags;
    logic [7:0]        hi_byte;
    logic [7:0]        count;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr;
    logic              accept;

    assign accept    = rx_valid && flags.rx_ready;
    assign rx_ready  = flags.rx_ready;
    assign busy      = flags.busy;
    assign cpu_reset = flags.cpu_reset;
    assign done      = flags.done;
    assign error     = flags.error;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            flags       <= flags_for(S_IDLE);
            hi_byte     <= '0;
            count       <= '0;
            sum         <= '0;
            addr        <= '0;
            ram_we      <= 1'b0;
            ram_wr_adr  <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state <= S_LEN;
                        flags <= flags_for(S_LEN);
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (rx_data == 8'd0) begin
                            state <= S_ERROR;
                            flags <= flags_for(S_ERROR);
                        end else begin
                            count <= rx_data;
                            addr  <= '0;
                            sum   <= '0;
                            state <= S_HI;
                            flags <= flags_for(S_HI);
                        end
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        sum     <= sum + rx_data;
                        state   <= S_LO;
                        flags   <= flags_for(S_LO);
                    end
                end
                S_LO: begin
                    if (accept) begin
                        sum         <= sum + rx_data;
                        ram_we      <= 1'b1;
                        ram_wr_adr  <= addr;
                        ram_wr_data <= DATA_W'({hi_byte, rx_data});
                        state       <= S_WR;
                        flags       <= flags_for(S_WR);
                    end
                end
                // The address counter stays internal so the RAM port holds its last value.
                S_WR: begin
                    if (addr == ADDR_W'(count - 8'd1)) begin
                        state <= S_CHK;
                        flags <= flags_for(S_CHK);
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= S_HI;
                        flags <= flags_for(S_HI);
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (rx_data == sum) begin
                            state <= S_DONE;
                            flags <= flags_for(S_DONE);
                        end else begin
                            state <= S_ERROR;
                            flags <= flags_for(S_ERROR);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flags <= flags_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; expected writes, checksum and
// timing come from a frame-level model built in the bench.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        ram_we;
    logic [7:0]  ram_wr_adr;
    logic [15:0] ram_wr_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    program_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_we     (ram_we),
        .ram_wr_adr (ram_wr_adr),
        .ram_wr_data(ram_wr_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  adr;
        logic [15:0] data;
    } wr_t;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          ready_viol = 0;
    int          double_we  = 0;
    int          timeouts   = 0;
    int          we_bad     = 0;
    logic        prev_we    = 1'b0;
    wr_t         mon_w;
    wr_t         writes[$];
    logic [15:0] exp_words[$];
    logic [7:0]  frame_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the RAM port and the ready/write handshake once per cycle.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            mon_w.adr  = ram_wr_adr;
            mon_w.data = ram_wr_data;
            writes.push_back(mon_w);
        end
        if (rx_ready !== (busy && !ram_we)) ready_viol++;
        if (ram_we === 1'b1 && prev_we === 1'b1) double_we++;
        prev_we = ram_we;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    // Frame model: COUNT, words high byte first, CHK = byte sum mod 256.
    task automatic build_frame(input bit corrupt);
        int s = 0;
        logic [7:0] chk;
        frame_bytes.delete();
        frame_bytes.push_back(8'(exp_words.size()));
        foreach (exp_words[i]) begin
            frame_bytes.push_back(exp_words[i][15:8]);
            frame_bytes.push_back(exp_words[i][7:0]);
            s = s + int'(exp_words[i][15:8]) + int'(exp_words[i][7:0]);
        end
        chk = 8'(s % 256);
        if (corrupt) chk = chk + 8'd1;
        frame_bytes.push_back(chk);
    endtask

    function automatic bit writes_match();
        if (writes.size() != exp_words.size()) return 1'b0;
        foreach (writes[i])
            if (writes[i].adr !== 8'(i) || writes[i].data !== exp_words[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic drive_byte(input logic [7:0] b, input bit gaps);
        bit accepted = 1'b0;
        int tries = 0;
        while (!accepted && tries < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
            end
            accepted = (rx_valid && rx_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
            tries++;
        end
        if (!accepted) timeouts++;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        writes.delete();
    endtask

    // Sends everything but the CHK byte, checking the write strobe after each LO byte.
    task automatic send_frame(input bit gaps);
        for (int k = 0; k < frame_bytes.size() - 1; k++) begin
            drive_byte(frame_bytes[k], gaps);
            if (k >= 2 && (k % 2) == 0) begin
                if (ram_we !== 1'b1 || ram_wr_adr !== 8'(k / 2 - 1) ||
                    ram_wr_data !== exp_words[k / 2 - 1]) we_bad++;
            end else if (ram_we !== 1'b0) begin
                we_bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({rx_ready, ram_we, cpu_reset, busy, done, error} !== 6'b001000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 001000", {rx_ready, ram_we, cpu_reset, busy, done, error});
        end
        compared++;
        if ({ram_wr_adr, ram_wr_data} !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_ram_port: got %h expected 000000", {ram_wr_adr, ram_wr_data});
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if ({rx_ready, busy, cpu_reset} !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL idle_hold: got %b expected 001", {rx_ready, busy, cpu_reset});
        end
    endtask

    task automatic test_normal();
        reset_dut();
        exp_words = '{16'h1234, 16'hABCD};
        build_frame(1'b0);
        do_start();
        compared++;
        if ({busy, rx_ready, done, error} !== 4'b1100) begin
            mismatched++;
            $display("[TB] FAIL normal_len_entry: got %b expected 1100", {busy, rx_ready, done, error});
        end
        send_frame(1'b0);
        compared++;
        if ({cpu_reset, done} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL normal_pre_chk: got %b expected 10", {cpu_reset, done});
        end
        drive_byte(frame_bytes[frame_bytes.size() - 1], 1'b0);
        rx_valid = 1'b0;
        compared++;
        if ({cpu_reset, done, error, busy} !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL normal_done: got %b expected 0100", {cpu_reset, done, error, busy});
        end
        compared++;
        if (!writes_match()) begin
            mismatched++;
            $display("[TB] FAIL normal_writes: got %0d writes expected %0d matching", writes.size(), exp_words.size());
        end
        compared++;
        if (we_bad !== 0) begin
            mismatched++;
            $display("[TB] FAIL normal_we_timing: got %0d late/wrong strobes expected 0", we_bad);
        end
    endtask

    task automatic test_bad_checksum();
        reset_dut();
        exp_words = '{16'h1234, 16'hABCD};
        build_frame(1'b1);
        do_start();
        send_frame(1'b0);
        drive_byte(frame_bytes[frame_bytes.size() - 1], 1'b0);
        rx_valid = 1'b0;
        compared++;
        if ({error, done, cpu_reset, busy} !== 4'b1010) begin
            mismatched++;
            $display("[TB] FAIL badchk_flags: got %b expected 1010", {error, done, cpu_reset, busy});
        end
        compared++;
        if (!writes_match()) begin
            mismatched++;
            $display("[TB] FAIL badchk_writes: got %0d writes expected %0d", writes.size(), exp_words.size());
        end
        repeat (3) @(negedge clk);
        compared++;
        if (error !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL badchk_sticky: got %b expected 1", error);
        end
        do_start();
        compared++;
        if ({error, busy, rx_ready} !== 3'b011) begin
            mismatched++;
            $display("[TB] FAIL badchk_restart: got %b expected 011", {error, busy, rx_ready});
        end
    endtask

    task automatic test_zero_count();
        reset_dut();
        do_start();
        drive_byte(8'h00, 1'b0);
        compared++;
        if ({error, done, busy, rx_ready, cpu_reset} !== 5'b10001) begin
            mismatched++;
            $display("[TB] FAIL zero_flags: got %b expected 10001", {error, done, busy, rx_ready, cpu_reset});
        end
        @(negedge clk);
        rx_valid = 1'b0;
        compared++;
        if (rx_ready !== 1'b0 || writes.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL zero_no_write: got ready=%b writes=%0d expected ready=0 writes=0", rx_ready, writes.size());
        end
    endtask

    task automatic test_backpressure();
        bit corrupt;
        int n;
        for (int r = 0; r < 4; r++) begin
            reset_dut();
            if (r == 0) begin
                exp_words = '{16'h1234, 16'hABCD};
                corrupt = 1'b0;
            end else begin
                n = $urandom_range(1, 16);
                exp_words.delete();
                for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
                corrupt = 1'($urandom_range(0, 1));
            end
            build_frame(corrupt);
            do_start();
            send_frame(1'b1);
            drive_byte(frame_bytes[frame_bytes.size() - 1], 1'b1);
            rx_valid = 1'b0;
            compared++;
            if ({done, error, cpu_reset} !== {!corrupt, corrupt, corrupt}) begin
                mismatched++;
                $display("[TB] FAIL bp_result[%0d]: got %b expected %b", r, {done, error, cpu_reset}, {!corrupt, corrupt, corrupt});
            end
            compared++;
            if (!writes_match()) begin
                mismatched++;
                $display("[TB] FAIL bp_writes[%0d]: got %0d writes expected %0d matching", r, writes.size(), exp_words.size());
            end
        end
        compared++;
        if (we_bad !== 0 || ready_viol !== 0) begin
            mismatched++;
            $display("[TB] FAIL bp_handshake: got we_bad=%0d ready_viol=%0d expected 0 and 0", we_bad, ready_viol);
        end
    endtask

    task automatic test_reset_mid_load();
        reset_dut();
        exp_words = '{16'h1234, 16'hABCD};
        build_frame(1'b0);
        do_start();
        for (int k = 0; k < 4; k++) drive_byte(frame_bytes[k], 1'b0);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hCD;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if ({rx_ready, ram_we, cpu_reset, busy, done, error} !== 6'b001000 || {ram_wr_adr, ram_wr_data} !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset_values: got %b/%h expected 001000/000000",
                     {rx_ready, ram_we, cpu_reset, busy, done, error}, {ram_wr_adr, ram_wr_data});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        compared++;
        if (writes.size() != 1 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_quiet: got writes=%0d busy=%b cpu_reset=%b expected 1 0 1", writes.size(), busy, cpu_reset);
        end
        writes.delete();
        do_start();
        send_frame(1'b0);
        drive_byte(frame_bytes[frame_bytes.size() - 1], 1'b0);
        rx_valid = 1'b0;
        compared++;
        if (done !== 1'b1 || !writes_match()) begin
            mismatched++;
            $display("[TB] FAIL midreset_reload: got done=%b writes=%0d expected 1 and 2", done, writes.size());
        end
    endtask

    task automatic test_start_ignored();
        reset_dut();
        exp_words = '{16'h0F0F, 16'h8001, 16'h7E42};
        build_frame(1'b0);
        do_start();
        drive_byte(frame_bytes[0], 1'b0);
        drive_byte(frame_bytes[1], 1'b0);
        rx_valid = 1'b0;
        do_start();
        compared++;
        if ({busy, rx_ready, error} !== 3'b110) begin
            mismatched++;
            $display("[TB] FAIL start_busy: got %b expected 110", {busy, rx_ready, error});
        end
        for (int k = 2; k < frame_bytes.size(); k++) drive_byte(frame_bytes[k], 1'b0);
        rx_valid = 1'b0;
        compared++;
        if (done !== 1'b1 || !writes_match()) begin
            mismatched++;
            $display("[TB] FAIL start_busy_result: got done=%b writes=%0d expected 1 and 3", done, writes.size());
        end
    endtask

    task automatic test_max_count();
        int len_cyc;
        int done_cyc;
        reset_dut();
        exp_words.delete();
        for (int i = 0; i < 255; i++) exp_words.push_back(16'(16'h0100 + i));
        build_frame(1'b0);
        do_start();
        len_cyc = cyc;
        send_frame(1'b0);
        drive_byte(frame_bytes[frame_bytes.size() - 1], 1'b0);
        done_cyc = cyc;
        rx_valid = 1'b0;
        compared++;
        if (done_cyc - len_cyc !== 1 + 3 * 255 + 1) begin
            mismatched++;
            $display("[TB] FAIL max_cycles: got %0d expected %0d", done_cyc - len_cyc, 1 + 3 * 255 + 1);
        end
        compared++;
        if (done !== 1'b1 || writes.size() != 255 || writes[writes.size() - 1].adr !== 8'd254) begin
            mismatched++;
            $display("[TB] FAIL max_last_write: got done=%b writes=%0d expected 1, 255 writes ending at adr 254", done, writes.size());
        end
        compared++;
        if (!writes_match()) begin
            mismatched++;
            $display("[TB] FAIL max_writes: got mismatched contents expected incrementing words");
        end
    endtask

    task automatic test_reset_and_start();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if ({busy, rx_ready, done, cpu_reset} !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL reset_wins: got %b expected 0001", {busy, rx_ready, done, cpu_reset});
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        compared++;
        if (double_we !== 0 || timeouts !== 0 || ready_viol !== 0) begin
            mismatched++;
            $display("[TB] FAIL protocol_totals: got double_we=%0d timeouts=%0d ready_viol=%0d expected 0 0 0",
                     double_we, timeouts, ready_viol);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_checksum();
        test_zero_count();
        test_backpressure();
        test_reset_mid_load();
        test_start_ignored();
        test_max_count();
        test_reset_and_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits upstream of the CPU's unified instruction/data RAM. It receives a framed byte stream over a valid/ready interface, assembles big-endian 16-bit words, and writes them into RAM at sequential addresses starting at 0. It holds the CPU in reset while loading and releases it only after the frame's checksum verifies.

## Interface
Parameters:
- ADDR_W, 8: RAM address width; matches the CPU's 8-bit PC/RAM address.
- DATA_W, 16: RAM word width; fixed at 2 bytes per word.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- ram_we  out  1  one-cycle RAM write strobe.
- ram_wr_adr  out  ADDR_W  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- cpu_reset  out  1  drives the CPU's reset; high means the CPU is held.
- busy  out  1  load in progress.
- done  out  1  last load completed and verified.
- error  out  1  last load failed; sticky.

## Operation
- Frame format: COUNT byte N (1..255), then N words sent high byte first, then a CHK byte.
- CHK must equal the 8-bit sum, mod 256, of all 2N data bytes. COUNT is not included in the sum.
- States:
  - IDLE: waits for start.
  - LEN: accepts COUNT. COUNT=0 goes to ERROR; otherwise clears the address counter and the sum, then goes to HI.
  - HI: accepts the high byte.
  - LO: accepts the low byte.
  - WR: pulses ram_we with the current address and word. Goes to CHK when address = N-1, otherwise increments the address and returns to HI.
  - CHK: accepts the CHK byte. Goes to DONE if it matches, otherwise to ERROR.
  - DONE and ERROR: terminal until start.
- A byte is accepted on any cycle with rx_valid && rx_ready. The running sum is updated on every accepted data byte.
- rx_ready = 1 only in LEN, HI, LO and CHK. It is 0 in IDLE, WR, DONE and ERROR.
- cpu_reset = 0 only in DONE; it is 1 in every other state. start in DONE re-asserts cpu_reset on the next cycle, which supports reload.
- busy = 1 in LEN, HI, LO, WR and CHK.
- done and error are asserted only in their named states. Both clear when start is accepted.
- start outside IDLE/DONE/ERROR is ignored. Bytes presented outside the ready states are not consumed.
- ram_wr_adr and ram_wr_data hold their last values when ram_we = 0.

## Timing
- Reset values: state IDLE, rx_ready 0, ram_we 0, ram_wr_adr 0, ram_wr_data 0, cpu_reset 1, busy 0, done 0, error 0, sum 0.
- start accepted at edge t: state is LEN at t+1 and rx_ready = 1 from t+1.
- Per-word latency:
  - Once the LO byte is accepted at edge t, ram_we = 1 during cycle t+1, with ram_wr_data = {hi, lo}.
  - The next HI byte can be accepted at edge t+2.
  - Minimum cost is 3 cycles per word with rx_valid held high.
- CHK byte accepted at edge t: done = 1 (or error = 1) from t+1. On success, cpu_reset falls at t+1.
- Full load with continuous rx_valid takes 1 + 3N + 1 cycles from LEN entry to DONE.
- COUNT = 0 accepted at edge t: error = 1 at t+1, with no RAM writes.
- Wrap-around: the address never wraps, because N ≤ 255 means the final address is ≤ 254.
- reset mid-load: returns to reset values on the next edge. No partial write strobe is issued. RAM contents already written are left as-is, and cpu_reset stays 1.
- reset and start asserted together: reset wins.

## Test plan
- Normal load: start, then bytes 02 12 34 AB CD BE. Expect writes adr0=0x1234 and adr1=0xABCD, done=1, cpu_reset 1→0 on the cycle after the CHK byte is accepted, and exactly 2 ram_we pulses.
- Bad checksum: the same frame with CHK=BF. Expect 2 writes, then error=1, cpu_reset held at 1, done=0. A following start clears error and returns to LEN.
- Zero count: start, then byte 00. Expect error=1 on the next cycle, no ram_we pulse, and rx_ready=0 afterwards.
- Backpressure and gaps: the normal frame with rx_valid toggled randomly and bytes presented during WR. Expect an identical result, and rx_ready=0 for exactly the WR cycle after each LO byte.
- Reset mid-load: assert reset after the HI byte of word 1. Expect all outputs at reset values on the next cycle and no further write. A subsequent full frame loads correctly.
- Max count: N=255 with incrementing words. Expect the final write at adr 254, done=1, and a total of 1+3·255+1 cycles from LEN entry to DONE with continuous valid.
